// File: rtl/corr_stream_pkg.sv
// corr_pkg: shared constants and helpers for the corr_stream correlator.
// The *_DEF values and the derived SW/NGRP/LEVELS/L describe the default build;
// parametrised modules derive their own copies through the helper functions.
package corr_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Width needed to hold a match count of 0..width.
  function automatic int score_w(input int width);
    return clog2(width + 1);
  endfunction

  localparam int WIDTH_DEF = 16;
  localparam int GROUP_DEF = 4;
  localparam int IDX_W_DEF = 8;

  localparam int SW     = clog2(WIDTH_DEF + 1);
  localparam int NGRP   = WIDTH_DEF / GROUP_DEF;
  localparam int LEVELS = clog2(NGRP);
  localparam int L      = 1 + LEVELS;

  localparam int              HCNT_W   = 16;
  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;

endpackage

// File: rtl/corr_stream_if.sv
// corr_stream_if: sample input, score output and peak-tracker signals of the
// correlator. hit_cnt exists only when CORR_HIT_CNT_EN is defined.
interface corr_stream_if #(
  parameter int WIDTH = corr_pkg::WIDTH_DEF,
  parameter int IDX_W = corr_pkg::IDX_W_DEF
);
  import corr_pkg::*;

  localparam int SCORE_W = score_w(WIDTH);

  logic               in_valid;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SCORE_W-1:0] thresh;
  logic               peak_clr;
  logic               out_valid;
  logic [SCORE_W-1:0] score;
  logic [IDX_W-1:0]   idx;
  logic               hit;
  logic [SCORE_W-1:0] peak_score;
  logic [IDX_W-1:0]   peak_idx;
`ifdef CORR_HIT_CNT_EN
  logic [HCNT_W-1:0]  hit_cnt;

  modport master (
    output in_valid, a, b, thresh, peak_clr,
    input  out_valid, score, idx, hit, peak_score, peak_idx, hit_cnt
  );
  modport slave (
    input  in_valid, a, b, thresh, peak_clr,
    output out_valid, score, idx, hit, peak_score, peak_idx, hit_cnt
  );
`else
  modport master (
    output in_valid, a, b, thresh, peak_clr,
    input  out_valid, score, idx, hit, peak_score, peak_idx
  );
  modport slave (
    input  in_valid, a, b, thresh, peak_clr,
    output out_valid, score, idx, hit, peak_score, peak_idx
  );
`endif
endinterface

// File: rtl/corr_stream_grp_pop.sv
// corr_grp_pop: match popcount of one GROUP-bit slice with its valid/tag copy.
// REG_OUT=0 makes the slice combinational; used only when the whole operand is a
// single group so that the score register remains the one pipeline stage.
module corr_grp_pop #(
  parameter int GROUP   = corr_pkg::GROUP_DEF,
  parameter int IDX_W   = corr_pkg::IDX_W_DEF,
  parameter bit REG_OUT = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  input  logic [IDX_W-1:0]                       tag_in,
  input  logic [GROUP-1:0]                       a,
  input  logic [GROUP-1:0]                       b,
  output logic [corr_pkg::clog2(GROUP+1)-1:0]    cnt,
  output logic                                   vld,
  output logic [IDX_W-1:0]                       tag
);
  import corr_pkg::*;

  localparam int CW = clog2(GROUP + 1);

  logic [CW-1:0] match;

  // count equal bit positions in the slice
  always_comb begin
    match = '0;
    for (int i = 0; i < GROUP; i++) match = match + CW'(a[i] ~^ b[i]);
  end

  if (REG_OUT) begin : g_reg
    // first pipeline stage: count, valid and tag advance together
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        vld <= 1'b0;
        tag <= '0;
      end else begin
        cnt <= match;
        vld <= in_valid;
        tag <= tag_in;
      end
    end
  end else begin : g_comb
    assign cnt = match;
    assign vld = in_valid;
    assign tag = tag_in;
  end

endmodule

// File: rtl/corr_stream.sv
// corr_stream: streaming bit-match correlator. Per-group registered popcounts
// feed a registered adder tree whose last level writes score/idx/hit directly,
// giving a latency of 1 + log2(WIDTH/GROUP) cycles. Also tracks the peak score.
// Optional build macro CORR_HIT_CNT_EN adds a saturating 16-bit hit counter.
module corr_stream #(
  parameter int WIDTH = corr_pkg::WIDTH_DEF,
  parameter int GROUP = corr_pkg::GROUP_DEF,
  parameter int IDX_W = corr_pkg::IDX_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  corr_stream_if.slave bus
);
  import corr_pkg::*;

  localparam int SCORE_W = score_w(WIDTH);
  localparam int N_GRP   = WIDTH / GROUP;
  localparam int N_LVL   = clog2(N_GRP);
  localparam int GW      = clog2(GROUP + 1);
  localparam int FW      = GW + N_LVL;

  logic [IDX_W-1:0] idx_cnt;

  // sample counter: current value tags the accepted sample, wraps silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            idx_cnt <= '0;
    else if (bus.in_valid) idx_cnt <= idx_cnt + IDX_W'(1);
  end

  logic [GW-1:0]    g_cnt [N_GRP];
  logic [N_GRP-1:0] g_vld;
  logic [IDX_W-1:0] g_tag [N_GRP];
  logic             l0_vld;
  logic [IDX_W-1:0] l0_tag;

  for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
    corr_grp_pop #(
      .GROUP  (GROUP),
      .IDX_W  (IDX_W),
      .REG_OUT(N_LVL > 0)
    ) u_pop (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_valid(bus.in_valid),
      .tag_in  (idx_cnt),
      .a       (bus.a[gi*GROUP +: GROUP]),
      .b       (bus.b[gi*GROUP +: GROUP]),
      .cnt     (g_cnt[gi]),
      .vld     (g_vld[gi]),
      .tag     (g_tag[gi])
    );
  end

  // every group holds an identical valid/tag copy; merging keeps all of them live
  always_comb begin
    l0_vld = &g_vld;
    l0_tag = '0;
    for (int i = 0; i < N_GRP; i++) l0_tag = l0_tag | g_tag[i];
  end

  // adder tree: level lv has NGRP>>lv nodes of GW+lv bits; the last level is
  // left combinational because the score register below is its stage
  for (genvar lv = 1; lv <= N_LVL; lv++) begin : g_lvl
    localparam int N = N_GRP >> lv;
    localparam int W = GW + lv;

    logic [W-2:0]     prv [2*N];
    logic             prv_vld;
    logic [IDX_W-1:0] prv_tag;
    logic [W-1:0]     nxt [N];
    logic [W-1:0]     sum [N];
    logic             vld;
    logic [IDX_W-1:0] tag;

    if (lv == 1) begin : g_src
      assign prv     = g_cnt;
      assign prv_vld = l0_vld;
      assign prv_tag = l0_tag;
    end else begin : g_src
      assign prv     = g_lvl[lv-1].sum;
      assign prv_vld = g_lvl[lv-1].vld;
      assign prv_tag = g_lvl[lv-1].tag;
    end

    // pairwise add with one bit of growth, never truncated
    always_comb begin
      for (int i = 0; i < N; i++) nxt[i] = {1'b0, prv[2*i]} + {1'b0, prv[2*i+1]};
    end

    if (lv < N_LVL) begin : g_reg
      // intermediate tree stage with its valid/tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) sum[i] <= '0;
          vld <= 1'b0;
          tag <= '0;
        end else begin
          sum <= nxt;
          vld <= prv_vld;
          tag <= prv_tag;
        end
      end
    end else begin : g_comb
      assign sum = nxt;
      assign vld = prv_vld;
      assign tag = prv_tag;
    end
  end

  logic [FW-1:0]      fin_sum;
  logic               fin_vld;
  logic [IDX_W-1:0]   fin_tag;
  logic [SCORE_W-1:0] fin_score;
  logic               hit_now;

  if (N_LVL == 0) begin : g_fin
    assign fin_sum = g_cnt[0];
    assign fin_vld = l0_vld;
    assign fin_tag = l0_tag;
  end else begin : g_fin
    assign fin_sum = g_lvl[N_LVL].sum[0];
    assign fin_vld = g_lvl[N_LVL].vld;
    assign fin_tag = g_lvl[N_LVL].tag;
  end

  // FW always equals SCORE_W for legal WIDTH/GROUP, so this is a pure extension
  assign fin_score = SCORE_W'(fin_sum);
  assign hit_now   = fin_vld && (fin_score >= bus.thresh);

  logic               out_valid_q;
  logic               hit_q;
  logic [SCORE_W-1:0] score_q;
  logic [IDX_W-1:0]   idx_q;
  logic [SCORE_W-1:0] peak_score_q;
  logic [IDX_W-1:0]   peak_idx_q;

  // output stage: score/idx hold across gaps, hit only on valid cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      score_q     <= '0;
      idx_q       <= '0;
    end else begin
      out_valid_q <= fin_vld;
      hit_q       <= hit_now;
      if (fin_vld) begin
        score_q <= fin_score;
        idx_q   <= fin_tag;
      end
    end
  end

  // peak tracker: clear wins and reloads from the in-flight result; strict
  // compare keeps the earlier sample on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_score_q <= '0;
      peak_idx_q   <= '0;
    end else if (bus.peak_clr) begin
      peak_score_q <= fin_vld ? fin_score : '0;
      peak_idx_q   <= fin_vld ? fin_tag : '0;
    end else if (fin_vld && (fin_score > peak_score_q)) begin
      peak_score_q <= fin_score;
      peak_idx_q   <= fin_tag;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.hit        = hit_q;
  assign bus.score      = score_q;
  assign bus.idx        = idx_q;
  assign bus.peak_score = peak_score_q;
  assign bus.peak_idx   = peak_idx_q;

`ifdef CORR_HIT_CNT_EN
  logic [HCNT_W-1:0] hit_cnt_q;

  // saturating hit counter, cleared with the peak tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hit_cnt_q <= '0;
    else if (bus.peak_clr)
      hit_cnt_q <= hit_now ? HCNT_W'(1) : '0;
    else if (hit_now && (hit_cnt_q != HCNT_MAX))
      hit_cnt_q <= hit_cnt_q + HCNT_W'(1);
  end

  assign bus.hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_corr_stream.sv
// Directed bench for corr_stream: default build, a 2-bit index build and a
// 32-bit build. hit_cnt checks are compiled in with CORR_HIT_CNT_EN.
module tb_corr_stream;
  import corr_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  corr_stream_if #(.WIDTH(16), .IDX_W(8)) i0 ();
  corr_stream_if #(.WIDTH(16), .IDX_W(2)) i1 ();
  corr_stream_if #(.WIDTH(32), .IDX_W(8)) i2 ();

  corr_stream #(.WIDTH(16), .GROUP(4), .IDX_W(8)) d0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  corr_stream #(.WIDTH(16), .GROUP(4), .IDX_W(2)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  corr_stream #(.WIDTH(32), .GROUP(4), .IDX_W(8)) d2 (.clk(clk), .rst_n(rst_n), .bus(i2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    i0.in_valid = 0; i0.a = '0; i0.b = '0; i0.thresh = '0; i0.peak_clr = 0;
    i1.in_valid = 0; i1.a = '0; i1.b = '0; i1.thresh = '0; i1.peak_clr = 0;
    i2.in_valid = 0; i2.a = '0; i2.b = '0; i2.thresh = '0; i2.peak_clr = 0;
  endtask

  task automatic do_reset;
    idle_all();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset;
    idle_all();
    rst_n = 0;
    #3;
    checks++; if (i0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", i0.out_valid); end
    checks++; if (i0.score !== 5'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", i0.score); end
    checks++; if (i0.idx !== 8'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", i0.idx); end
    checks++; if (i0.hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", i0.hit); end
    checks++; if (i0.peak_score !== 5'd0) begin errors++; $display("FAIL reset_peak_score: got %0d expected 0", i0.peak_score); end
    checks++; if (i0.peak_idx !== 8'd0) begin errors++; $display("FAIL reset_peak_idx: got %0d expected 0", i0.peak_idx); end
    checks++; if (i2.out_valid !== 1'b0 || i2.score !== 6'd0) begin errors++; $display("FAIL reset_wide: got valid %b score %0d expected 0 0", i2.out_valid, i2.score); end
`ifdef CORR_HIT_CNT_EN
    checks++; if (i0.hit_cnt !== 16'd0) begin errors++; $display("FAIL reset_hit_cnt: got %0d expected 0", i0.hit_cnt); end
`endif
    tick();
    rst_n = 1;
    tick();
  endtask

  // a=b, a=~b, a^b=0001 -> 16, 0, 15 on ticks 3..5
  task automatic test_basic;
    logic [15:0] va [3] = '{16'hFFFF, 16'h0000, 16'hFFFE};
    int          es [3] = '{16, 0, 15};
    logic        ev;
    do_reset();
    for (int t = 1; t <= 6; t++) begin
      if (t <= 3) begin i0.in_valid = 1; i0.a = va[t-1]; i0.b = 16'hFFFF; end
      else        begin i0.in_valid = 0; i0.a = 16'h5555; end
      tick();
      ev = (t >= 3 && t <= 5);
      checks++; if (i0.out_valid !== ev) begin errors++; $display("FAIL basic_valid t=%0d: got %b expected %b", t, i0.out_valid, ev); end
      checks++; if (i0.hit !== ev) begin errors++; $display("FAIL basic_hit t=%0d: got %b expected %b", t, i0.hit, ev); end
      if (ev) begin
        checks++; if (i0.score !== es[t-3]) begin errors++; $display("FAIL basic_score t=%0d: got %0d expected %0d", t, i0.score, es[t-3]); end
        checks++; if (i0.idx !== t-3) begin errors++; $display("FAIL basic_idx t=%0d: got %0d expected %0d", t, i0.idx, t-3); end
      end
    end
    checks++; if (i0.peak_score !== 16 || i0.peak_idx !== 0) begin errors++; $display("FAIL basic_peak: got %0d/%0d expected 16/0", i0.peak_score, i0.peak_idx); end
  endtask

  // in_valid 1,0,1: output gap, score/idx hold, hit low in the gap
  task automatic test_gap;
    logic ev [6] = '{0, 0, 1, 0, 1, 0};
    int   es [6] = '{0, 0, 16, 16, 8, 8};
    int   ei [6] = '{0, 0, 0, 0, 1, 1};
    do_reset();
    for (int t = 1; t <= 6; t++) begin
      i0.b = 16'hFFFF;
      case (t)
        1:       begin i0.in_valid = 1; i0.a = 16'hFFFF; end
        2:       begin i0.in_valid = 0; i0.a = 16'h0000; end
        3:       begin i0.in_valid = 1; i0.a = 16'h00FF; end
        default: begin i0.in_valid = 0; i0.a = 16'h0000; end
      endcase
      tick();
      checks++; if (i0.out_valid !== ev[t-1]) begin errors++; $display("FAIL gap_valid t=%0d: got %b expected %b", t, i0.out_valid, ev[t-1]); end
      checks++; if (i0.hit !== ev[t-1]) begin errors++; $display("FAIL gap_hit t=%0d: got %b expected %b", t, i0.hit, ev[t-1]); end
      if (t >= 3) begin
        checks++; if (i0.score !== es[t-1]) begin errors++; $display("FAIL gap_score t=%0d: got %0d expected %0d", t, i0.score, es[t-1]); end
        checks++; if (i0.idx !== ei[t-1]) begin errors++; $display("FAIL gap_idx t=%0d: got %0d expected %0d", t, i0.idx, ei[t-1]); end
      end
    end
  endtask

  // scores 10,14,12,9 against thresh 12 then 0; then 16 vs thresh 16 and 17
  task automatic test_hit;
    logic [15:0] va [4] = '{16'h03FF, 16'h3FFF, 16'h0FFF, 16'h01FF};
    int          es [4] = '{10, 14, 12, 9};
    logic        eh [2][4] = '{'{0, 1, 1, 0}, '{1, 1, 1, 1}};
    for (int p = 0; p < 2; p++) begin
      do_reset();
      i0.thresh = (p == 0) ? 5'd12 : 5'd0;
      for (int t = 1; t <= 7; t++) begin
        if (t <= 4) begin i0.in_valid = 1; i0.a = va[t-1]; i0.b = 16'hFFFF; end
        else        i0.in_valid = 0;
        tick();
        if (t >= 3 && t <= 6) begin
          checks++; if (i0.score !== es[t-3]) begin errors++; $display("FAIL hit_score p=%0d t=%0d: got %0d expected %0d", p, t, i0.score, es[t-3]); end
          checks++; if (i0.hit !== eh[p][t-3]) begin errors++; $display("FAIL hit_flag p=%0d t=%0d: got %b expected %b", p, t, i0.hit, eh[p][t-3]); end
        end else begin
          checks++; if (i0.hit !== 1'b0) begin errors++; $display("FAIL hit_idle p=%0d t=%0d: got %b expected 0", p, t, i0.hit); end
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      i0.thresh = (p == 0) ? 5'd16 : 5'd17;
      i0.in_valid = 1; i0.a = 16'hA5A5; i0.b = 16'hA5A5;
      tick();
      i0.in_valid = 0;
      tick();
      tick();
      checks++; if (i0.out_valid !== 1'b1 || i0.hit !== (p == 0)) begin errors++; $display("FAIL hit_bound thresh=%0d: got valid %b hit %b expected 1 %b", i0.thresh, i0.out_valid, i0.hit, p == 0); end
    end
  endtask

  // peak: 10,14,14,9 with peak_clr on the score-9 output, then clr when idle
  task automatic test_peak;
    logic [15:0] va [4] = '{16'h03FF, 16'h3FFF, 16'h3FFF, 16'h01FF};
    int          eps [8] = '{0, 0, 10, 14, 14, 9, 9, 9};
    int          epi [8] = '{0, 0, 0, 1, 1, 3, 3, 3};
    do_reset();
    for (int t = 1; t <= 8; t++) begin
      if (t <= 4) begin i0.in_valid = 1; i0.a = va[t-1]; i0.b = 16'hFFFF; end
      else        i0.in_valid = 0;
      i0.peak_clr = (t == 6);
      tick();
      checks++; if (i0.peak_score !== eps[t-1] || i0.peak_idx !== epi[t-1]) begin errors++; $display("FAIL peak t=%0d: got %0d/%0d expected %0d/%0d", t, i0.peak_score, i0.peak_idx, eps[t-1], epi[t-1]); end
    end
    i0.peak_clr = 1;
    tick();
    i0.peak_clr = 0;
    checks++; if (i0.peak_score !== 0 || i0.peak_idx !== 0) begin errors++; $display("FAIL peak_clr_idle: got %0d/%0d expected 0/0", i0.peak_score, i0.peak_idx); end
  endtask

  // IDX_W=2 wrap, then reset with two samples in flight
  task automatic test_idx_wrap;
    do_reset();
    for (int t = 1; t <= 9; t++) begin
      i1.in_valid = (t <= 7); i1.a = 16'h1234; i1.b = 16'h1234;
      tick();
      if (t >= 3) begin
        checks++; if (i1.out_valid !== 1'b1 || i1.idx !== ((t - 3) % 4)) begin errors++; $display("FAIL wrap_idx t=%0d: got valid %b idx %0d expected 1 %0d", t, i1.out_valid, i1.idx, (t - 3) % 4); end
      end
    end
    i1.in_valid = 1;
    tick();
    tick();
    i1.in_valid = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++; if (i1.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid t=%0d: got %b expected 0", t, i1.out_valid); end
    end
    i1.in_valid = 1;
    tick();
    i1.in_valid = 0;
    tick();
    tick();
    checks++; if (i1.out_valid !== 1'b1 || i1.idx !== 2'd0) begin errors++; $display("FAIL post_reset_idx: got valid %b idx %0d expected 1 0", i1.out_valid, i1.idx); end
  endtask

  // WIDTH=32 (latency 4); with the counter option, saturation and clears
  task automatic test_wide;
`ifdef CORR_HIT_CNT_EN
    localparam int NS = 70000;
`else
    localparam int NS = 8;
`endif
    do_reset();
    i2.thresh = '0;
    for (int t = 1; t <= NS; t++) begin
      i2.in_valid = 1;
      i2.a = (t == 1) ? 32'hFFFF0000 : 32'h00000000;
      i2.b = (t == 1) ? 32'hFFFFFFFF : 32'h00000000;
      tick();
      if (t == 3) begin
        checks++; if (i2.out_valid !== 1'b0) begin errors++; $display("FAIL wide_lat3: got %b expected 0", i2.out_valid); end
      end
      if (t == 4) begin
        checks++; if (i2.out_valid !== 1'b1 || i2.score !== 16 || i2.idx !== 0) begin errors++; $display("FAIL wide_first: got %b %0d %0d expected 1 16 0", i2.out_valid, i2.score, i2.idx); end
      end
      if (t == 5) begin
        checks++; if (i2.score !== 32 || i2.idx !== 1 || i2.hit !== 1'b1) begin errors++; $display("FAIL wide_equal: got %0d %0d %b expected 32 1 1", i2.score, i2.idx, i2.hit); end
      end
`ifdef CORR_HIT_CNT_EN
      if (t == 1003) begin
        checks++; if (i2.hit_cnt !== 16'd1000) begin errors++; $display("FAIL hit_cnt_mid: got %0d expected 1000", i2.hit_cnt); end
      end
`endif
    end
    checks++; if (i2.peak_score !== 32 || i2.peak_idx !== 1) begin errors++; $display("FAIL wide_peak: got %0d/%0d expected 32/1", i2.peak_score, i2.peak_idx); end
`ifdef CORR_HIT_CNT_EN
    checks++; if (i2.hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL hit_cnt_sat: got %0h expected ffff", i2.hit_cnt); end
    i2.in_valid = 0;
    for (int t = 0; t < 5; t++) tick();
    checks++; if (i2.hit_cnt !== 16'hFFFF) begin errors++; $display("FAIL hit_cnt_hold: got %0h expected ffff", i2.hit_cnt); end
    i2.peak_clr = 1;
    tick();
    i2.peak_clr = 0;
    checks++; if (i2.hit_cnt !== 16'd0 || i2.peak_score !== 0 || i2.peak_idx !== 0) begin errors++; $display("FAIL hit_cnt_clr: got %0d %0d/%0d expected 0 0/0", i2.hit_cnt, i2.peak_score, i2.peak_idx); end
    i2.in_valid = 1;
    tick();
    i2.in_valid = 0;
    tick();
    tick();
    i2.peak_clr = 1;
    tick();
    i2.peak_clr = 0;
    checks++; if (i2.hit_cnt !== 16'd1 || i2.peak_score !== 32 || i2.peak_idx !== 112) begin errors++; $display("FAIL clr_with_hit: got %0d %0d/%0d expected 1 32/112", i2.hit_cnt, i2.peak_score, i2.peak_idx); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_hit();
    test_peak();
    test_idx_wrap();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
